// File: rtl/controle_pkg.sv
// Shared state codes and motor command encodings for the obstacle-avoidance
// sequencer.
package controle_pkg;

    typedef enum logic [2:0] {
        PARADO    = 3'd0,
        FRENTE    = 3'd1,
        RE        = 3'd2,
        GIRAR_DIR = 3'd3,
        GIRAR_ESQ = 3'd4,
        ERRO      = 3'd5
    } estado_t;

    localparam logic [1:0] MOTOR_PARA   = 2'b00;
    localparam logic [1:0] MOTOR_FRENTE = 2'b01;
    localparam logic [1:0] MOTOR_RE     = 2'b10;

endpackage

// File: rtl/sincronizador.sv
// Two-flop synchronizer bank that brings asynchronous sensor levels into the
// clk domain.
module sincronizador #(
    parameter int LARGURA = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [LARGURA-1:0] assincrono,
    output logic [LARGURA-1:0] sincrono
);

    logic [LARGURA-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta     <= '0;
            sincrono <= '0;
        end else begin
            meta     <= assincrono;
            sincrono <= meta;
        end
    end

endmodule

// File: rtl/controle_movimento.sv
// Timed obstacle-avoidance sequencer: drives forward, reverses and turns for
// programmed cycle counts, and latches an error when the robot is boxed in.
module controle_movimento
    import controle_pkg::*;
#(
    parameter int RE_CICLOS    = 8,
    parameter int GIRO_CICLOS  = 6,
    parameter int LARGURA_CONT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       Sensor_Frontal,
    input  logic       Sensor_Direito,
    input  logic       Sensor_Esquerdo,
    input  logic       Sensor_Trazeiro,
    input  logic       habilita,
    input  logic       limpa_erro,
    output logic [1:0] Motor_Esq,
    output logic [1:0] Motor_Dir,
    output logic       Saida_Re,
    output logic       Saida_Girar,
    output logic       Saida_Erro,
    output logic [2:0] Estado
);

    localparam logic [LARGURA_CONT-1:0] CARGA_RE   = LARGURA_CONT'(RE_CICLOS - 1);
    localparam logic [LARGURA_CONT-1:0] CARGA_GIRO = LARGURA_CONT'(GIRO_CICLOS - 1);
    localparam logic [LARGURA_CONT-1:0] UM         = LARGURA_CONT'(1);

    logic [3:0]              sensores;
    logic                    sf, sd, se, st;
    logic                    bloqueio;
    estado_t                 estado;
    logic [LARGURA_CONT-1:0] timer;

    sincronizador #(.LARGURA(4)) u_sincronizador (
        .clk        (clk),
        .rst_n      (rst_n),
        .assincrono ({Sensor_Frontal, Sensor_Direito, Sensor_Esquerdo, Sensor_Trazeiro}),
        .sincrono   (sensores)
    );

    assign {sf, sd, se, st} = sensores;
    assign bloqueio = sf & sd & se & st;

    // Priority: bloqueio, then loss of habilita, then per-state transitions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado <= PARADO;
            timer  <= '0;
        end else if (estado != ERRO && bloqueio) begin
            estado <= ERRO;
        end else if (!habilita && (estado inside {FRENTE, RE, GIRAR_DIR, GIRAR_ESQ})) begin
            estado <= PARADO;
        end else begin
            case (estado)
                PARADO: begin
                    if (habilita) estado <= FRENTE;
                end
                FRENTE: begin
                    if (sf || (sd && se)) begin
                        estado <= RE;
                        timer  <= CARGA_RE;
                    end else if (se) begin
                        estado <= GIRAR_DIR;
                        timer  <= CARGA_GIRO;
                    end else if (sd) begin
                        estado <= GIRAR_ESQ;
                        timer  <= CARGA_GIRO;
                    end
                end
                RE: begin
                    if (sf && st) begin
                        estado <= ERRO;
                    end else if (st || timer == '0) begin
                        // Turn away from whichever side is blocked.
                        estado <= sd ? GIRAR_ESQ : GIRAR_DIR;
                        timer  <= CARGA_GIRO;
                    end else begin
                        timer <= timer - UM;
                    end
                end
                GIRAR_DIR, GIRAR_ESQ: begin
                    if (timer == '0) estado <= FRENTE;
                    else             timer  <= timer - UM;
                end
                ERRO: begin
                    if (limpa_erro && !bloqueio) estado <= PARADO;
                end
                default: estado <= PARADO;
            endcase
        end
    end

    always_comb begin
        Motor_Esq   = MOTOR_PARA;
        Motor_Dir   = MOTOR_PARA;
        Saida_Re    = 1'b0;
        Saida_Girar = 1'b0;
        Saida_Erro  = 1'b0;
        case (estado)
            FRENTE: begin
                Motor_Esq = MOTOR_FRENTE;
                Motor_Dir = MOTOR_FRENTE;
            end
            RE: begin
                Motor_Esq = MOTOR_RE;
                Motor_Dir = MOTOR_RE;
                Saida_Re  = 1'b1;
            end
            GIRAR_DIR: begin
                Motor_Esq   = MOTOR_FRENTE;
                Motor_Dir   = MOTOR_RE;
                Saida_Girar = 1'b1;
            end
            GIRAR_ESQ: begin
                Motor_Esq   = MOTOR_RE;
                Motor_Dir   = MOTOR_FRENTE;
                Saida_Girar = 1'b1;
            end
            ERRO: Saida_Erro = 1'b1;
            default: ;
        endcase
    end

    assign Estado = estado;

endmodule

// File: tb/tb_controle_movimento.sv
// Directed bench for controle_movimento with a cycle model of the manoeuvre
// rules and hand-computed checkpoints.
module tb_controle_movimento;

    localparam int RE_C   = 4;
    localparam int GIRO_C = 3;

    localparam logic [2:0] M_PARADO = 3'd0;
    localparam logic [2:0] M_FRENTE = 3'd1;
    localparam logic [2:0] M_RE     = 3'd2;
    localparam logic [2:0] M_GDIR   = 3'd3;
    localparam logic [2:0] M_GESQ   = 3'd4;
    localparam logic [2:0] M_ERRO   = 3'd5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic Sensor_Frontal = 1'b0;
    logic Sensor_Direito = 1'b0;
    logic Sensor_Esquerdo = 1'b0;
    logic Sensor_Trazeiro = 1'b0;
    logic habilita = 1'b0;
    logic limpa_erro = 1'b0;
    logic [1:0] Motor_Esq, Motor_Dir;
    logic Saida_Re, Saida_Girar, Saida_Erro;
    logic [2:0] Estado;

    int n_checks = 0;
    int n_erros = 0;
    logic ativo = 1'b0;

    controle_movimento #(
        .RE_CICLOS    (RE_C),
        .GIRO_CICLOS  (GIRO_C),
        .LARGURA_CONT (16)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .Sensor_Frontal  (Sensor_Frontal),
        .Sensor_Direito  (Sensor_Direito),
        .Sensor_Esquerdo (Sensor_Esquerdo),
        .Sensor_Trazeiro (Sensor_Trazeiro),
        .habilita        (habilita),
        .limpa_erro      (limpa_erro),
        .Motor_Esq       (Motor_Esq),
        .Motor_Dir       (Motor_Dir),
        .Saida_Re        (Saida_Re),
        .Saida_Girar     (Saida_Girar),
        .Saida_Erro      (Saida_Erro),
        .Estado          (Estado)
    );

    always #5 clk = ~clk;

    // Model: mode plus cycles remaining in the current manoeuvre.
    logic [2:0] m_modo = M_PARADO;
    logic [4:0] m_rest = 5'd0;
    logic [3:0] atraso1 = 4'd0;
    logic [3:0] atraso2 = 4'd0;

    logic [1:0] tab_esq [0:5] = '{2'b00, 2'b01, 2'b10, 2'b01, 2'b10, 2'b00};
    logic [1:0] tab_dir [0:5] = '{2'b00, 2'b01, 2'b10, 2'b10, 2'b01, 2'b00};

    function automatic logic [7:0] passo(input logic [2:0] m, input logic [4:0] r,
                                         input logic [3:0] s, input logic hab, input logic clr);
        logic f, d, e, t, bloq;
        f = s[3]; d = s[2]; e = s[1]; t = s[0];
        bloq = &s;
        if (m != M_ERRO && bloq) return {M_ERRO, 5'd0};
        if (m != M_PARADO && m != M_ERRO && !hab) return {M_PARADO, 5'd0};
        case (m)
            M_PARADO: return hab ? {M_FRENTE, 5'd0} : {M_PARADO, 5'd0};
            M_FRENTE: begin
                if (f || (d && e)) return {M_RE, 5'(RE_C)};
                if (e) return {M_GDIR, 5'(GIRO_C)};
                if (d) return {M_GESQ, 5'(GIRO_C)};
                return {M_FRENTE, 5'd0};
            end
            M_RE: begin
                if (f && t) return {M_ERRO, 5'd0};
                if (t || r == 5'd1) return {(d ? M_GESQ : M_GDIR), 5'(GIRO_C)};
                return {M_RE, r - 5'd1};
            end
            M_GDIR, M_GESQ: begin
                if (r == 5'd1) return {M_FRENTE, 5'd0};
                return {m, r - 5'd1};
            end
            M_ERRO: return (clr && !bloq) ? {M_PARADO, 5'd0} : {M_ERRO, 5'd0};
            default: return {M_PARADO, 5'd0};
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_modo  <= M_PARADO;
            m_rest  <= 5'd0;
            atraso1 <= 4'd0;
            atraso2 <= 4'd0;
        end else begin
            {m_modo, m_rest} <= passo(m_modo, m_rest, atraso2, habilita, limpa_erro);
            atraso1 <= {Sensor_Frontal, Sensor_Direito, Sensor_Esquerdo, Sensor_Trazeiro};
            atraso2 <= atraso1;
        end
    end

    always @(negedge clk) begin
        if (ativo) begin
            n_checks++;
            if (Estado !== m_modo || Motor_Esq !== tab_esq[m_modo] || Motor_Dir !== tab_dir[m_modo] ||
                Saida_Re !== (m_modo == M_RE) || Saida_Girar !== (m_modo == M_GDIR || m_modo == M_GESQ) ||
                Saida_Erro !== (m_modo == M_ERRO)) begin
                n_erros++;
                $display("FAIL ciclo t=%0t: got estado=%0d motor=%b/%b re=%b girar=%b erro=%b, expected estado=%0d motor=%b/%b",
                         $time, Estado, Motor_Esq, Motor_Dir, Saida_Re, Saida_Girar, Saida_Erro,
                         m_modo, tab_esq[m_modo], tab_dir[m_modo]);
            end
        end
    end

    task automatic confere(input string nome, input int atual, input int esperado);
        n_checks++;
        if (atual != esperado) begin
            n_erros++;
            $display("FAIL %s: got %0d expected %0d", nome, atual, esperado);
        end
    endtask

    task automatic ciclos(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        ciclos(3);
        ativo = 1'b1;
        confere("reset_estado", Estado, 0);
        confere("reset_motor", {Motor_Esq, Motor_Dir}, 4'b0000);
        confere("reset_flags", {Saida_Re, Saida_Girar, Saida_Erro}, 3'b000);

        rst_n = 1'b1;
        ciclos(1);
        confere("parado_sem_habilita", Estado, 0);
        habilita = 1'b1;
        ciclos(1);
        confere("frente_estado", Estado, 1);
        confere("frente_motor", {Motor_Esq, Motor_Dir}, 4'b0101);

        // Frontal pulse: reverse 4 cycles, then turn right 3 cycles.
        Sensor_Frontal = 1'b1; ciclos(1); Sensor_Frontal = 1'b0; ciclos(2);
        confere("re_entrada", Estado, 2);
        confere("re_motor", {Motor_Esq, Motor_Dir}, 4'b1010);
        confere("re_flag", Saida_Re, 1);
        ciclos(3);
        confere("re_quarto_ciclo", Estado, 2);
        ciclos(1);
        confere("giro_dir_estado", Estado, 3);
        confere("giro_dir_motor", {Motor_Esq, Motor_Dir}, 4'b0110);
        confere("giro_dir_flag", Saida_Girar, 1);
        ciclos(2);
        confere("giro_dir_terceiro", Estado, 3);
        ciclos(1);
        confere("volta_frente", Estado, 1);

        Sensor_Esquerdo = 1'b1; ciclos(1); Sensor_Esquerdo = 1'b0; ciclos(2);
        confere("esquerdo_gira_dir", Estado, 3);
        ciclos(3);
        confere("esquerdo_fim", Estado, 1);

        Sensor_Direito = 1'b1; ciclos(1); Sensor_Direito = 1'b0; ciclos(2);
        confere("direito_gira_esq", Estado, 4);
        confere("giro_esq_motor", {Motor_Esq, Motor_Dir}, 4'b1001);
        ciclos(3);
        confere("direito_fim", Estado, 1);

        // Rear plus right obstacle during reversing ends it early.
        Sensor_Frontal = 1'b1; ciclos(1); Sensor_Frontal = 1'b0; ciclos(1);
        Sensor_Trazeiro = 1'b1; Sensor_Direito = 1'b1; ciclos(1);
        confere("antecipada_re1", Estado, 2);
        Sensor_Trazeiro = 1'b0; Sensor_Direito = 1'b0; ciclos(1);
        confere("antecipada_re2", Estado, 2);
        ciclos(1);
        confere("antecipada_giro_esq", Estado, 4);
        ciclos(3);
        confere("antecipada_fim", Estado, 1);

        // Front and rear together while reversing: boxed in.
        Sensor_Frontal = 1'b1; Sensor_Trazeiro = 1'b1; ciclos(3);
        confere("encurralado_re", Estado, 2);
        ciclos(1);
        confere("encurralado_erro", Estado, 5);
        confere("erro_motor", {Motor_Esq, Motor_Dir}, 4'b0000);
        confere("erro_flag", Saida_Erro, 1);
        ciclos(2);
        confere("erro_mantido", Estado, 5);
        limpa_erro = 1'b1; Sensor_Frontal = 1'b0; Sensor_Trazeiro = 1'b0; ciclos(1);
        confere("limpa_sai_erro", Estado, 0);
        limpa_erro = 1'b0; ciclos(3);
        confere("apos_limpa_frente", Estado, 1);

        // All four sensors: clear is ignored until one drops.
        {Sensor_Frontal, Sensor_Direito, Sensor_Esquerdo, Sensor_Trazeiro} = 4'b1111; ciclos(3);
        confere("bloqueio_erro", Estado, 5);
        limpa_erro = 1'b1; ciclos(3);
        confere("limpa_ignorado", Estado, 5);
        habilita = 1'b0; Sensor_Esquerdo = 1'b0; ciclos(2);
        confere("bloqueio_pipeline", Estado, 5);
        ciclos(1);
        confere("bloqueio_solto", Estado, 0);
        {Sensor_Frontal, Sensor_Direito, Sensor_Esquerdo, Sensor_Trazeiro} = 4'b0000;
        limpa_erro = 1'b0; ciclos(3);
        confere("parado_sem_hab", Estado, 0);

        // Dropping habilita in the middle of reversing.
        habilita = 1'b1; ciclos(1);
        Sensor_Frontal = 1'b1; ciclos(1); Sensor_Frontal = 1'b0; ciclos(2);
        confere("aborta_re_entrada", Estado, 2);
        ciclos(1);
        habilita = 1'b0; ciclos(1);
        confere("habilita_aborta", Estado, 0);

        // Asynchronous reset in the middle of a turn.
        habilita = 1'b1; ciclos(1);
        Sensor_Esquerdo = 1'b1; ciclos(1); Sensor_Esquerdo = 1'b0; ciclos(2);
        confere("giro_antes_reset", Estado, 3);
        @(posedge clk); #2;
        rst_n = 1'b0; #1;
        confere("reset_assinc_estado", Estado, 0);
        confere("reset_assinc_motor", {Motor_Esq, Motor_Dir}, 4'b0000);
        confere("reset_assinc_flags", {Saida_Re, Saida_Girar, Saida_Erro}, 3'b000);
        ciclos(2);
        rst_n = 1'b1; ciclos(2);
        confere("pos_reset_frente", Estado, 1);

        $display("Result: errors=%0d of %0d checks", n_erros, n_checks);
        $finish;
    end

endmodule
